// File: rtl/seg_scan_ctrl.sv
// Basys3 four-digit seven-segment scan controller with frame-synchronous double buffering.
// Define SEG_LEAD_ZERO_BLANK_EN to suppress leading zeros on digits 3..1.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [19:0] load_data,
  input  logic [3:0]  digit_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int MaxSlot = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CntW    = (MaxSlot > 1) ? $clog2(MaxSlot) : 1;
  localparam logic [CntW-1:0] DriveLast = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);

  typedef enum logic {BLANK, DRIVE} scanState_t;

  scanState_t      state, nextState;
  logic [1:0]      digitIdx, nextIdx;
  logic [CntW-1:0] slotCnt, nextCnt;
  logic            boundary;
  logic [19:0]     activeBuf, pendingBuf;
  logic            pendingFull;
  logic [3:0]      selDigit;
  logic [3:0]      dpBits;
  logic [3:0]      leadShow;
  logic [3:0]      nextAn;
  logic [6:0]      nextSeg;
  logic            nextDp;

  function automatic logic [6:0] hexToSeg(input logic [3:0] hex);
    case (hex)
      4'h0:    hexToSeg = 7'b1000000;
      4'h1:    hexToSeg = 7'b1111001;
      4'h2:    hexToSeg = 7'b0100100;
      4'h3:    hexToSeg = 7'b0110000;
      4'h4:    hexToSeg = 7'b0011001;
      4'h5:    hexToSeg = 7'b0010010;
      4'h6:    hexToSeg = 7'b0000010;
      4'h7:    hexToSeg = 7'b1111000;
      4'h8:    hexToSeg = 7'b0000000;
      4'h9:    hexToSeg = 7'b0010000;
      4'hA:    hexToSeg = 7'b0001000;
      4'hB:    hexToSeg = 7'b0000011;
      4'hC:    hexToSeg = 7'b1000110;
      4'hD:    hexToSeg = 7'b0100001;
      4'hE:    hexToSeg = 7'b0000110;
      default: hexToSeg = 7'b0001110;
    endcase
  endfunction

  // Slot sequencing: BLANK then DRIVE per digit; the last DRIVE cycle of digit 3 is the frame boundary.
  always_comb begin
    nextState = state;
    nextIdx   = digitIdx;
    nextCnt   = slotCnt + 1'b1;
    boundary  = 1'b0;
    case (state)
      BLANK: begin
        if (slotCnt == BlankLast) begin
          nextState = DRIVE;
          nextCnt   = '0;
        end
      end
      DRIVE: begin
        if (slotCnt == DriveLast) begin
          nextState = BLANK;
          nextCnt   = '0;
          nextIdx   = digitIdx + 2'd1;
          boundary  = (digitIdx == 2'd3);
        end
      end
      default: begin
        nextState = BLANK;
        nextCnt   = '0;
      end
    endcase
  end

  assign dpBits = activeBuf[19:16];

`ifdef SEG_LEAD_ZERO_BLANK_EN
  assign leadShow[0] = 1'b1;
  assign leadShow[1] = dpBits[1] | (activeBuf[15:4]  != 12'd0);
  assign leadShow[2] = dpBits[2] | (activeBuf[15:8]  != 8'd0);
  assign leadShow[3] = dpBits[3] | (activeBuf[15:12] != 4'd0);
`else
  assign leadShow = 4'b1111;
`endif

  // Outputs are computed for the upcoming state so the registered pins match the live state.
  always_comb begin
    case (digitIdx)
      2'd0:    selDigit = activeBuf[3:0];
      2'd1:    selDigit = activeBuf[7:4];
      2'd2:    selDigit = activeBuf[11:8];
      default: selDigit = activeBuf[15:12];
    endcase
    nextAn  = 4'b1111;
    nextSeg = 7'b1111111;
    nextDp  = 1'b1;
    if (nextState == DRIVE && digit_en[digitIdx] && leadShow[digitIdx]) begin
      nextAn[digitIdx] = 1'b0;
      nextSeg          = hexToSeg(selDigit);
      nextDp           = ~dpBits[digitIdx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BLANK;
      digitIdx    <= '0;
      slotCnt     <= '0;
      activeBuf   <= '0;
      pendingBuf  <= '0;
      pendingFull <= 1'b0;
      load_ready  <= 1'b0;
      an          <= 4'b1111;
      seg         <= 7'b1111111;
      dp          <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      state      <= nextState;
      digitIdx   <= nextIdx;
      slotCnt    <= nextCnt;
      an         <= nextAn;
      seg        <= nextSeg;
      dp         <= nextDp;
      frame_done <= boundary;
      // A load and a commit never coincide: a load needs the pending buffer empty.
      if (boundary && pendingFull) begin
        activeBuf   <= pendingBuf;
        pendingFull <= 1'b0;
        load_ready  <= 1'b1;
      end else if (load_valid && load_ready) begin
        pendingBuf  <= load_data;
        pendingFull <= 1'b1;
        load_ready  <= 1'b0;
      end else begin
        load_ready  <= ~pendingFull;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: loads are queued as issued and a cycle-accurate
// frame-arithmetic model checks every output pin on the falling edge.
module tb_seg_scan_ctrl;

  localparam int RefreshDiv  = 4;
  localparam int BlankCycles = 2;
  localparam int SlotLen     = RefreshDiv + BlankCycles;
  localparam int FrameLen    = 4 * SlotLen;
`ifdef SEG_LEAD_ZERO_BLANK_EN
  localparam bit LeadZeroBlank = 1'b1;
`else
  localparam bit LeadZeroBlank = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic [19:0] load_data = '0;
  logic [3:0]  digit_en = 4'hF;
  logic        load_ready;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int compared = 0;
  int mismatched = 0;

  logic [19:0] expQ[$];

  logic        modelValid = 1'b0;
  int          cyc = 0;
  logic [19:0] activeVal = '0;
  logic [19:0] pendingVal = '0;
  logic        pendingFull = 1'b0;
  logic [3:0]  enPrev = 4'hF;
  int          pos;
  int          dig;
  logic        inDrive;
  logic [3:0]  expAn;
  logic [6:0]  expSeg;
  logic        expDp;

  logic [6:0] segTable [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg_scan_ctrl #(
    .REFRESH_DIV (RefreshDiv),
    .BLANK_CYCLES(BlankCycles)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .digit_en  (digit_en),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic bit digitShown(input logic [19:0] v, input int k);
    return !LeadZeroBlank || (k == 0) || v[16+k] || ((v[15:0] >> (4 * k)) != 16'd0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d of scan, time %0t)", name, actual, expected, cyc, $time);
    end
  endtask

  // Monitor: compare against the model for this cycle, then advance the model across the next edge.
  always @(negedge clk) begin
    if (modelValid) begin
      pos     = cyc % FrameLen;
      dig     = pos / SlotLen;
      inDrive = (pos % SlotLen) >= BlankCycles;
      expAn   = 4'b1111;
      expSeg  = 7'b1111111;
      expDp   = 1'b1;
      if (inDrive && enPrev[dig] && digitShown(activeVal, dig)) begin
        expAn[dig] = 1'b0;
        expSeg     = segTable[activeVal[4*dig +: 4]];
        expDp      = !activeVal[16+dig];
      end
      checkOutput("an", 32'(an), 32'(expAn));
      checkOutput("seg", 32'(seg), 32'(expSeg));
      checkOutput("dp", 32'(dp), 32'(expDp));
      checkOutput("frame_done", 32'(frame_done), 32'(cyc > 0 && pos == 0));
      checkOutput("load_ready", 32'(load_ready), 32'(cyc > 0 && !pendingFull));
    end
    if (reset) begin
      modelValid  = 1'b1;
      cyc         = 0;
      activeVal   = '0;
      pendingFull = 1'b0;
    end else if (modelValid) begin
      if (((cyc + 1) % FrameLen == 0) && pendingFull) begin
        activeVal   = pendingVal;
        pendingFull = 1'b0;
      end else if (load_valid && cyc > 0 && !pendingFull) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL scoreboard: got a transfer with no queued value, expected none");
        end else begin
          pendingVal  = expQ.pop_front();
          pendingFull = 1'b1;
        end
      end
      cyc++;
    end
    enPrev = digit_en;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic resetPulse();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input logic [19:0] value);
    int waitCycles = 0;
    load_data  = value;
    load_valid = 1'b1;
    expQ.push_back(value);
    @(negedge clk);
    while (!load_ready && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!load_ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL load_accept: got no load_ready within 200 cycles, expected acceptance");
      void'(expQ.pop_back());
    end
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  task automatic waitFrameDone();
    int waitCycles = 0;
    @(negedge clk);
    while (!frame_done && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!frame_done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL frame_wait: got no frame_done within 100 cycles, expected a pulse");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion by %0t, expected $finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(30);

    idle(7);
    applyStimulus(20'h0_1234);
    idle(60);

    applyStimulus(20'h0_00AF);
    applyStimulus(20'h0_0008);
    idle(60);

    digit_en = 4'b0101;
    applyStimulus(20'h1_5678);
    idle(60);

    digit_en = 4'hF;
    waitFrameDone();
    applyStimulus(20'h0_9999);
    idle(12);
    resetPulse();
    idle(60);

    for (int i = 0; i < 60; i++) begin
      digit_en = 4'($urandom);
      idle($urandom_range(0, 40));
      if ($urandom_range(0, 9) == 0) resetPulse();
      else applyStimulus(20'($urandom));
    end

    digit_en = 4'hF;
    idle(5);
    applyStimulus(20'h0_0040);
    idle(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
